// File: rtl/ysyx_22040365_lsu.sv
// ysyx_22040365_lsu: RV64 memory-access stage with valid/ready bus and one-cycle writeback bundle.
// Optional misaligned-access trap: define YSYX_22040365_MISALIGN_CHK_EN.
module ysyx_22040365_lsu #(
   parameter int XLEN = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_result,
   input  logic [XLEN-1:0]   in_store_data,
   input  logic              in_mem_rd,
   input  logic              in_mem_wr,
   input  logic [2:0]        in_funct3,
   input  logic              in_rd_en,
   input  logic [4:0]        in_rd_addr,
   input  logic [31:0]       in_inst,
   input  logic [XLEN-1:0]   in_pc,
   output logic              req_valid,
   input  logic              req_ready,
   output logic [XLEN-1:0]   req_addr,
   output logic              req_wen,
   output logic [XLEN-1:0]   req_wdata,
   output logic [XLEN/8-1:0] req_wmask,
   input  logic              rsp_valid,
   input  logic [XLEN-1:0]   rsp_rdata,
   output logic [XLEN-1:0]   result_78,
   output logic              rd_en_78,
   output logic [4:0]        rd_addr_78,
   output logic [31:0]       inst_78,
   output logic [XLEN-1:0]   pc_78,
   output logic              valid_78,
   output logic              exc_misalign
);
   localparam int MW = XLEN / 8;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] RSP  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;
   logic [1:0]      r_state, w_next;
   logic [XLEN-1:0] r_result;
   logic [2:0]      r_funct3;
   logic            r_rd_en;
   logic [4:0]      r_rd_addr;
   logic [31:0]     r_inst;
   logic [XLEN-1:0] r_pc;
   logic            w_acc, w_mem, w_mis, w_direct, w_resp;
   logic [MW-1:0]   w_size;
   logic [XLEN-1:0] w_sh, w_load;
   assign in_ready  = (r_state == IDLE) | (r_state == DONE);
   assign req_valid = r_state == REQ;
   assign valid_78  = r_state == DONE;
   assign w_acc     = in_valid & in_ready;
   assign w_mem     = in_mem_rd | in_mem_wr;
`ifdef YSYX_22040365_MISALIGN_CHK_EN
   logic r_exc;
   assign w_mis = w_mem & (in_funct3[1:0] == 2'd1 ? in_result[0] :
                           in_funct3[1:0] == 2'd2 ? |in_result[1:0] :
                           in_funct3[1:0] == 2'd3 ? |in_result[2:0] : 1'b0);
   assign exc_misalign = r_exc & valid_78;
`else
   assign w_mis = 1'b0;
   assign exc_misalign = 1'b0;
`endif
   assign w_direct = w_acc & ~(w_mem & ~w_mis);
   assign w_resp   = (r_state == RSP) & rsp_valid;
   assign w_size   = in_funct3[1:0] == 2'd0 ? MW'(8'h01) :
                     in_funct3[1:0] == 2'd1 ? MW'(8'h03) :
                     in_funct3[1:0] == 2'd2 ? MW'(8'h0F) : MW'(8'hFF);
   // Lanes shifted past the top byte fall off; no cross-doubleword access.
   assign w_sh   = rsp_rdata >> {req_addr[2:0], 3'b000};
   assign w_load = r_funct3 == 3'b000 ? {{(XLEN-8){w_sh[7]}}, w_sh[7:0]} :
                   r_funct3 == 3'b001 ? {{(XLEN-16){w_sh[15]}}, w_sh[15:0]} :
                   r_funct3 == 3'b010 ? {{(XLEN-32){w_sh[31]}}, w_sh[31:0]} :
                   r_funct3 == 3'b100 ? {{(XLEN-8){1'b0}}, w_sh[7:0]} :
                   r_funct3 == 3'b101 ? {{(XLEN-16){1'b0}}, w_sh[15:0]} :
                   r_funct3 == 3'b110 ? {{(XLEN-32){1'b0}}, w_sh[31:0]} : w_sh;
   assign w_next = w_acc ? ((w_mem & ~w_mis) ? REQ : DONE) :
                   r_state == REQ ? (req_ready ? RSP : REQ) :
                   r_state == RSP ? (rsp_valid ? DONE : RSP) : IDLE;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_result   <= '0;
         r_funct3   <= '0;
         r_rd_en    <= 1'b0;
         r_rd_addr  <= '0;
         r_inst     <= '0;
         r_pc       <= '0;
         req_addr   <= '0;
         req_wen    <= 1'b0;
         req_wdata  <= '0;
         req_wmask  <= '0;
         result_78  <= '0;
         rd_en_78   <= 1'b0;
         rd_addr_78 <= '0;
         inst_78    <= '0;
         pc_78      <= '0;
`ifdef YSYX_22040365_MISALIGN_CHK_EN
         r_exc      <= 1'b0;
`endif
      end else begin
         r_state <= w_next;
         if (w_acc) begin
            r_result  <= in_result;
            r_funct3  <= in_funct3;
            r_rd_en   <= in_rd_en;
            r_rd_addr <= in_rd_addr;
            r_inst    <= in_inst;
            r_pc      <= in_pc;
            req_addr  <= in_result;
            req_wen   <= in_mem_wr;
            req_wdata <= in_store_data << {in_result[2:0], 3'b000};
            req_wmask <= w_size << in_result[2:0];
         end
         if (w_direct) begin
            result_78  <= in_result;
            rd_en_78   <= in_rd_en & ~w_mis;
            rd_addr_78 <= in_rd_addr;
            inst_78    <= in_inst;
            pc_78      <= in_pc;
`ifdef YSYX_22040365_MISALIGN_CHK_EN
            r_exc      <= w_mis;
`endif
         end else if (w_resp) begin
            result_78  <= req_wen ? r_result : w_load;
            rd_en_78   <= r_rd_en;
            rd_addr_78 <= r_rd_addr;
            inst_78    <= r_inst;
            pc_78      <= r_pc;
`ifdef YSYX_22040365_MISALIGN_CHK_EN
            r_exc      <= 1'b0;
`endif
         end
      end
   end
endmodule

// File: tb/tb_ysyx_22040365_lsu.sv
// tb_ysyx_22040365_lsu: directed plus randomized checks of the LSU against a byte-lane reference model.
module tb_ysyx_22040365_lsu;
   logic        clk = 0, rst = 0, in_valid = 0, in_mem_rd = 0, in_mem_wr = 0, in_rd_en = 0;
   logic        req_ready = 0, rsp_valid = 0;
   logic [63:0] in_result = 0, in_store_data = 0, in_pc = 0, rsp_rdata = 0;
   logic [2:0]  in_funct3 = 0;
   logic [4:0]  in_rd_addr = 0;
   logic [31:0] in_inst = 0;
   logic        in_ready, req_valid, req_wen, rd_en_78, valid_78, exc_misalign;
   logic [63:0] req_addr, req_wdata, result_78, pc_78;
   logic [7:0]  req_wmask;
   logic [4:0]  rd_addr_78;
   logic [31:0] inst_78;
   int total = 0, bad = 0;

   ysyx_22040365_lsu dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_store_data(in_store_data), .in_mem_rd(in_mem_rd),
      .in_mem_wr(in_mem_wr), .in_funct3(in_funct3), .in_rd_en(in_rd_en),
      .in_rd_addr(in_rd_addr), .in_inst(in_inst), .in_pc(in_pc),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .result_78(result_78),
      .rd_en_78(rd_en_78), .rd_addr_78(rd_addr_78), .inst_78(inst_78),
      .pc_78(pc_78), .valid_78(valid_78), .exc_misalign(exc_misalign)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] m_load(input logic [2:0] f, input logic [63:0] addr, input logic [63:0] rd);
      int n = 1 << f[1:0];
      logic [63:0] keep = (n == 8) ? ~64'd0 : (64'd1 << (8 * n)) - 1;
      logic [63:0] v = (rd >> (8 * addr[2:0])) & keep;
      if (!f[2] && v[8 * n - 1]) v = v | ~keep;
      return v;
   endfunction

   function automatic logic [7:0] m_mask(input logic [2:0] f, input logic [63:0] addr);
      int n = 1 << f[1:0];
      logic [15:0] m = ((16'd1 << n) - 16'd1) << addr[2:0];
      return m[7:0];
   endfunction

   function automatic logic m_mis(input logic [2:0] f, input logic [63:0] addr);
      int n = 1 << f[1:0];
      return (addr & 64'(n - 1)) != 0;
   endfunction

   task automatic do_op(input logic rd, input logic wr, input logic [2:0] f, input logic [63:0] addr,
                        input logic [63:0] sdata, input logic [63:0] rdata, input logic [4:0] rda,
                        input int dreq, input int drsp, input logic glitch);
      logic mem, mis, wb_en;
      logic [31:0] inst;
      logic [63:0] pc, exp_res;
      mem = rd | wr;
`ifdef YSYX_22040365_MISALIGN_CHK_EN
      mis = mem && m_mis(f, addr);
`else
      mis = 1'b0;
`endif
      for (int i = 0; i < 10 && !in_ready; i++) begin @(posedge clk); #1; end
      chk("in_ready_before_accept", in_ready, 1);
      inst = $urandom; pc = {$urandom, $urandom}; wb_en = wr ? 1'b0 : 1'b1;
      in_valid = 1; in_mem_rd = rd; in_mem_wr = wr; in_funct3 = f; in_result = addr;
      in_store_data = sdata; in_rd_en = wb_en; in_rd_addr = rda; in_inst = inst; in_pc = pc;
      @(posedge clk); #1;
      in_valid = 0; in_mem_rd = 0; in_mem_wr = 0;
      if (mem && !mis) begin
         for (int i = 0; i <= dreq; i++) begin
            chk("req_valid", req_valid, 1);
            chk("req_addr", req_addr, addr);
            chk("req_wen", req_wen, wr);
            chk("in_ready_busy", in_ready, 0);
            if (wr) begin
               chk("req_wdata", req_wdata, sdata << (8 * addr[2:0]));
               chk("req_wmask", req_wmask, m_mask(f, addr));
            end
            rsp_valid = glitch && i == 0 && dreq > 0;
            rsp_rdata = ~rdata;
            req_ready = (i == dreq);
            @(posedge clk); #1;
         end
         req_ready = 0;
         for (int i = 0; i <= drsp; i++) begin
            chk("req_valid_in_rsp", req_valid, 0);
            chk("valid_78_early", valid_78, 0);
            rsp_valid = (i == drsp);
            rsp_rdata = rdata;
            @(posedge clk); #1;
         end
         rsp_valid = 0;
      end
      exp_res = (rd && !mis) ? m_load(f, addr, rdata) : addr;
      chk("valid_78", valid_78, 1);
      if (!mis) chk("result_78", result_78, exp_res);
      chk("rd_en_78", rd_en_78, wb_en & !mis);
      chk("rd_addr_78", rd_addr_78, rda);
      chk("inst_78", inst_78, inst);
      chk("pc_78", pc_78, pc);
      chk("exc_misalign", exc_misalign, mis);
      chk("req_valid_done", req_valid, 0);
   endtask

   initial begin
      logic [63:0] rnd;
      repeat (2) @(posedge clk);
      #1 rst = 1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_req_valid", req_valid, 0);
      chk("rst_valid_78", valid_78, 0);
      chk("rst_result_78", result_78, 0);

      do_op(0, 0, 0, 64'h1234, 0, 0, 5'd5, 0, 0, 0);
      do_op(0, 0, 0, 64'h1234, 0, 0, 5'd5, 0, 0, 0);
      chk("alu_result_const", result_78, 64'h1234);
      @(posedge clk); #1;
      chk("idle_valid_78", valid_78, 0);
      chk("idle_result_hold", result_78, 64'h1234);

      do_op(1, 0, 3'b000, 64'h8000_0003, 0, 64'h0000_0000_8000_0000, 5'd3, 3, 1, 1);
      chk("lb_const", result_78, 64'hFFFF_FFFF_FFFF_FF80);
      do_op(1, 0, 3'b100, 64'h8000_0003, 0, 64'h0000_0000_8000_0000, 5'd3, 1, 0, 0);
      chk("lbu_const", result_78, 64'h80);
      do_op(0, 1, 3'b001, 64'h8000_0006, 64'hABCD, 0, 5'd0, 2, 2, 1);
      rnd = {$urandom, $urandom};
      do_op(1, 0, 3'b011, 64'h8000_0004, 0, rnd, 5'd9, 0, 0, 0);
`ifndef YSYX_22040365_MISALIGN_CHK_EN
      chk("ld_misaligned_shift", result_78, rnd >> 32);
`endif

      @(posedge clk); #1;
      in_valid = 1; in_mem_rd = 1; in_funct3 = 0; in_result = 64'h8000_0003;
      in_rd_en = 1; in_rd_addr = 7; in_inst = 32'hdead; in_pc = 64'h100;
      @(posedge clk); #1;
      in_valid = 0; in_mem_rd = 0;
      chk("mid_req_valid", req_valid, 1);
      #2 rst = 0;
      #1 chk("rst_async_req_drop", req_valid, 0);
      rsp_valid = 1; rsp_rdata = '1;
      @(posedge clk); #1;
      @(posedge clk); #1 rst = 1;
      chk("rel_in_ready", in_ready, 1);
      chk("rel_req_valid", req_valid, 0);
      chk("rel_req_addr", req_addr, 0);
      chk("rel_req_wen", req_wen, 0);
      chk("rel_req_wdata", req_wdata, 0);
      chk("rel_req_wmask", req_wmask, 0);
      chk("rel_valid_78", valid_78, 0);
      chk("rel_result_78", result_78, 0);
      chk("rel_rd_en_78", rd_en_78, 0);
      chk("rel_rd_addr_78", rd_addr_78, 0);
      chk("rel_inst_78", inst_78, 0);
      chk("rel_pc_78", pc_78, 0);
      chk("rel_exc", exc_misalign, 0);
      @(posedge clk); #1;
      chk("stray_rsp_valid_78", valid_78, 0);
      chk("stray_rsp_req_valid", req_valid, 0);
      rsp_valid = 0;

      for (int k = 0; k < 60; k++) begin
         int kind;
         logic [2:0] f;
         kind = $urandom_range(0, 2);
         f = (kind == 2) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
         do_op(kind == 1, kind == 2, f, {$urandom, $urandom}, {$urandom, $urandom},
               {$urandom, $urandom}, 5'($urandom), $urandom_range(0, 3),
               $urandom_range(0, 3), 1'($urandom));
         if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
